// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for two requesters (ALU, load unit) into a single register-file
// write port, with a pending-register scoreboard for operand hazard queries.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  input  logic [4:0]       s0_rd,
  input  logic [XLEN-1:0]  s0_data,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [4:0]       s1_rd,
  input  logic [XLEN-1:0]  s1_data,
  output logic             s1_ready,
  input  logic             issue_en,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rr1,
  input  logic [4:0]       rr2,
  output logic             rr1_busy,
  output logic             rr2_busy,
  output logic             wr_en,
  output logic [4:0]       wrr,
  output logic [XLEN-1:0]  wrdata,
  output logic [NREGS-1:0] pending
);

  logic             lp;
  logic             gnt1;
  logic             xfer_p0;
  logic [4:0]       sel_rd_p0;
  logic [XLEN-1:0]  sel_data_p0;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] pending_nxt;

  function automatic logic busy_of(input logic [NREGS-1:0] pend, input logic [4:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (idx == 5'(i)) b = pend[i];
    end
    return b;
  endfunction

  // Stage p0: round-robin grant; requester 1 wins only alone or when 0 was granted last
  always_comb begin
    gnt1        = s1_valid && (!s0_valid || (lp == 1'b0));
    s0_ready    = !rst && s0_valid && !gnt1;
    s1_ready    = !rst && s1_valid && gnt1;
    xfer_p0     = s0_ready || s1_ready;
    sel_rd_p0   = gnt1 ? s1_rd : s0_rd;
    sel_data_p0 = gnt1 ? s1_data : s0_data;
  end

  // Stage p1: registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      lp     <= 1'b1;
      wr_en  <= 1'b0;
      wrr    <= '0;
      wrdata <= '0;
    end else begin
      wr_en <= xfer_p0 && (sel_rd_p0 != 5'd0);
      if (xfer_p0) begin
        lp     <= gnt1;
        wrr    <= sel_rd_p0;
        wrdata <= sel_data_p0;
      end
    end
  end

  // Set from issue overrides clear from a completing write on the same register
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < NREGS; i++) begin
      set_vec[i] = issue_en && (issue_rd == 5'(i));
      clr_vec[i] = wr_en && (wrr == 5'(i));
    end
    pending_nxt    = (pending & ~clr_vec) | set_vec;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  always_comb begin
    rr1_busy = busy_of(pending, rr1);
    rr2_busy = busy_of(pending, rr2);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: reset, arbitration, write latency,
// scoreboard set/clear interactions and mid-operation reset.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [4:0]  s0_rd, s1_rd, issue_rd, rr1, rr2, wrr;
  logic [31:0] s0_data, s1_data, wrdata, pending;
  logic        issue_en, rr1_busy, rr2_busy, wr_en;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] d0, d1;
  logic        exp0;

  regfile_wb_arbiter #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data), .s1_ready(s1_ready),
    .issue_en(issue_en), .issue_rd(issue_rd), .rr1(rr1), .rr2(rr2),
    .rr1_busy(rr1_busy), .rr2_busy(rr2_busy),
    .wr_en(wr_en), .wrr(wrr), .wrdata(wrdata), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; s0_valid = 0; s1_valid = 0; s0_rd = 0; s1_rd = 0;
    s0_data = 0; s1_data = 0; issue_en = 0; issue_rd = 0; rr1 = 0; rr2 = 0;
    tick(); tick();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wrr", 64'(wrr), 64'd0);
    chk("rst_wrdata", 64'(wrdata), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    s0_valid = 1; s1_valid = 1; #1;
    chk("rst_s0_ready", 64'(s0_ready), 64'd0);
    chk("rst_s1_ready", 64'(s1_ready), 64'd0);
    s0_valid = 0; s1_valid = 0;
    tick();
    rst = 1'b0;

    // Single requester write, latency 1
    s0_valid = 1; s0_rd = 5; s0_data = 32'hDEADBEEF; #1;
    chk("single_s0_ready", 64'(s0_ready), 64'd1);
    chk("single_s1_ready", 64'(s1_ready), 64'd0);
    tick();
    s0_valid = 0; #1;
    chk("single_wr_en", 64'(wr_en), 64'd1);
    chk("single_wrr", 64'(wrr), 64'd5);
    chk("single_wrdata", 64'(wrdata), 64'hDEADBEEF);
    tick();
    chk("single_wr_en_drop", 64'(wr_en), 64'd0);
    chk("single_wrr_hold", 64'(wrr), 64'd5);
    chk("single_wrdata_hold", 64'(wrdata), 64'hDEADBEEF);

    // Reset restores pointer so s0 wins first contention
    rst = 1; tick(); rst = 0;
    d0 = 32'h100; d1 = 32'h200;
    for (int k = 0; k < 6; k++) begin
      s0_valid = 1; s0_rd = 1; s0_data = d0;
      s1_valid = 1; s1_rd = 2; s1_data = d1; #1;
      exp0 = (k % 2 == 0);
      chk($sformatf("rr_s0_ready_%0d", k), 64'(s0_ready), 64'(exp0));
      chk($sformatf("rr_s1_ready_%0d", k), 64'(s1_ready), 64'(!exp0));
      tick();
      chk($sformatf("rr_wr_en_%0d", k), 64'(wr_en), 64'd1);
      chk($sformatf("rr_wrr_%0d", k), 64'(wrr), exp0 ? 64'd1 : 64'd2);
      chk($sformatf("rr_wrdata_%0d", k), 64'(wrdata), exp0 ? 64'(d0) : 64'(d1));
      if (exp0) d0 = d0 + 1; else d1 = d1 + 1;
    end
    s0_valid = 0; s1_valid = 0;
    tick();
    chk("rr_idle_wr_en", 64'(wr_en), 64'd0);

    // Scoreboard set then clear by writeback
    issue_en = 1; issue_rd = 7; rr1 = 7; #1;
    chk("sb_busy_before", 64'(rr1_busy), 64'd0);
    tick();
    issue_en = 0; #1;
    chk("sb_busy_set", 64'(rr1_busy), 64'd1);
    chk("sb_pending_set", 64'(pending), 64'h80);
    s1_valid = 1; s1_rd = 7; s1_data = 32'h77; #1;
    chk("sb_s1_ready", 64'(s1_ready), 64'd1);
    tick();
    s1_valid = 0; #1;
    chk("sb_wr_en", 64'(wr_en), 64'd1);
    chk("sb_busy_during_wr", 64'(rr1_busy), 64'd1);
    tick();
    chk("sb_busy_cleared", 64'(rr1_busy), 64'd0);
    chk("sb_pending_cleared", 64'(pending), 64'd0);

    // Write to x0 accepted but suppressed
    issue_en = 1; issue_rd = 3; tick(); issue_en = 0;
    rr1 = 0; rr2 = 3;
    s0_valid = 1; s0_rd = 0; s0_data = 32'h12345678; #1;
    chk("x0_s0_ready", 64'(s0_ready), 64'd1);
    tick();
    s0_valid = 0; #1;
    chk("x0_wr_en", 64'(wr_en), 64'd0);
    chk("x0_pending", 64'(pending), 64'h8);
    chk("x0_rr1_busy", 64'(rr1_busy), 64'd0);
    chk("x0_rr2_busy", 64'(rr2_busy), 64'd1);

    // Issue of x0 is ignored
    issue_en = 1; issue_rd = 0; tick(); issue_en = 0; #1;
    chk("x0_issue_ignored", 64'(pending), 64'h8);

    // Same-edge set and clear: set wins
    issue_en = 1; issue_rd = 9; tick(); issue_en = 0;
    s1_valid = 1; s1_rd = 9; s1_data = 32'h99; tick();
    s1_valid = 0;
    issue_en = 1; issue_rd = 9; #1;
    chk("setclr_wr_en", 64'(wr_en), 64'd1);
    chk("setclr_wrr", 64'(wrr), 64'd9);
    tick();
    issue_en = 0; #1;
    chk("setclr_pending", 64'(pending), 64'h208);

    // Reset with a write in flight
    s0_valid = 1; s0_rd = 4; s0_data = 32'h44; tick();
    rst = 1; s1_valid = 1; s1_rd = 6; s1_data = 32'h66; #1;
    chk("midrst_s0_ready", 64'(s0_ready), 64'd0);
    chk("midrst_s1_ready", 64'(s1_ready), 64'd0);
    tick();
    rst = 0; #1;
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_s0_wins", 64'(s0_ready), 64'd1);
    chk("midrst_s1_loses", 64'(s1_ready), 64'd0);
    tick();
    s0_valid = 0; #1;
    chk("midrst_wrr", 64'(wrr), 64'd4);
    chk("midrst_wrdata", 64'(wrdata), 64'h44);
    chk("midrst_s1_now", 64'(s1_ready), 64'd1);
    s1_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
